// File: rtl/commit_trace_serializer_if.sv
// Retire-stage inputs and commit-record output stream of the co-simulation trace serializer.
// The serializer connects through the slave modport; the core/checker side uses master.
interface commit_trace_serializer_if #(
  parameter int unsigned COMMITS = 2
);
  logic [COMMITS-1:0]    in_valid;
  logic [64*COMMITS-1:0] in_pc;
  logic [32*COMMITS-1:0] in_insn;
  logic [COMMITS-1:0]    in_wen;
  logic [5*COMMITS-1:0]  in_waddr;
  logic [64*COMMITS-1:0] in_wdata;
  logic                  trap_valid;
  logic [63:0]           trap_cause;
  logic                  in_ready;

  logic                  out_valid;
  logic                  out_ready;
  logic [63:0]           out_pc;
  logic [31:0]           out_insn;
  logic                  out_wen;
  logic [4:0]            out_waddr;
  logic [63:0]           out_wdata;
  logic                  out_trap;
  logic [63:0]           out_cause;
  logic [31:0]           out_seq;
  logic                  overflow;

  modport master (
    output in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata, trap_valid, trap_cause,
    output out_ready,
    input  in_ready, out_valid, out_pc, out_insn, out_wen, out_waddr, out_wdata,
    input  out_trap, out_cause, out_seq, overflow
  );

  modport slave (
    input  in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata, trap_valid, trap_cause,
    input  out_ready,
    output in_ready, out_valid, out_pc, out_insn, out_wen, out_waddr, out_wdata,
    output out_trap, out_cause, out_seq, overflow
  );
endinterface

// File: rtl/commit_trace_serializer.sv
// Commit trace serializer: compacts up to COMMITS retires plus one trap per cycle into an
// in-order FIFO and emits one registered commit record per cycle on a valid/ready port.
package commit_trace_serializer_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        trap;
    logic [63:0] cause;
  } trace_rec_t;
endpackage

module commit_trace_serializer
  import commit_trace_serializer_pkg::*;
#(
  parameter int unsigned COMMITS = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  commit_trace_serializer_if.slave   bus_io
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  trace_rec_t       head_q, head_d;
  trace_rec_t       mem_q [DEPTH];
  trace_rec_t       mem_d [DEPTH];

  logic             any_in;
  logic             deq;
  logic [CNT_W-1:0] enq_n;
  logic [PTR_W-1:0] widx;
  trace_rec_t       rec;

  // Next-state: compacted lane writes, trap write, pointer/count/sequence update.
  always_comb begin
    mem_d       = mem_q;
    enq_n       = '0;
    widx        = '0;
    rec         = '0;
    any_in      = (|bus_io.in_valid) || bus_io.trap_valid;
    deq         = out_valid_q && bus_io.out_ready;

    if (in_ready_q) begin
      for (int i = 0; i < COMMITS; i++) begin
        if (bus_io.in_valid[i]) begin
          rec       = '0;
          rec.pc    = bus_io.in_pc[64*i +: 64];
          rec.insn  = bus_io.in_insn[32*i +: 32];
          rec.wen   = bus_io.in_wen[i];
          if (bus_io.in_wen[i]) begin
            rec.waddr = bus_io.in_waddr[5*i +: 5];
            rec.wdata = bus_io.in_wdata[64*i +: 64];
          end
          widx        = wr_ptr_q + PTR_W'(enq_n);
          mem_d[widx] = rec;
          enq_n       = enq_n + CNT_W'(1);
        end
      end
      if (bus_io.trap_valid) begin
        rec         = '0;
        rec.trap    = 1'b1;
        rec.cause   = bus_io.trap_cause;
        widx        = wr_ptr_q + PTR_W'(enq_n);
        mem_d[widx] = rec;
        enq_n       = enq_n + CNT_W'(1);
      end
    end

    count_d     = count_q + enq_n - CNT_W'(deq);
    wr_ptr_d    = wr_ptr_q + PTR_W'(enq_n);
    rd_ptr_d    = rd_ptr_q + PTR_W'(deq);
    seq_d       = seq_q + 32'(deq);
    overflow_d  = overflow_q || (any_in && !in_ready_q);
    // Ready is granted only when a full retire group plus a trap is guaranteed to fit.
    in_ready_d  = (CNT_W'(DEPTH) - count_d) >= CNT_W'(COMMITS + 1);
    out_valid_d = (count_d != '0);
    head_d      = out_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  // Control and head-record registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      seq_q       <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      seq_q       <= seq_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_pc    = head_q.pc;
  assign bus_io.out_insn  = head_q.insn;
  assign bus_io.out_wen   = head_q.wen;
  assign bus_io.out_waddr = head_q.waddr;
  assign bus_io.out_wdata = head_q.wdata;
  assign bus_io.out_trap  = head_q.trap;
  assign bus_io.out_cause = head_q.cause;
  assign bus_io.out_seq   = seq_q;
  assign bus_io.overflow  = overflow_q;

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed self-checking bench for commit_trace_serializer (COMMITS=2, DEPTH=8).
module tb_commit_trace_serializer;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  commit_trace_serializer_if #(.COMMITS(2)) bus ();

  commit_trace_serializer #(.COMMITS(2), .DEPTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [63:0] pc, input logic [31:0] insn,
                         input logic wen, input logic [4:0] waddr, input logic [63:0] wdata,
                         input logic trap, input logic [63:0] cause, input logic [31:0] seq);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".pc"},    bus.out_pc, pc);
    chk({tag, ".insn"},  64'(bus.out_insn), 64'(insn));
    chk({tag, ".wen"},   64'(bus.out_wen), 64'(wen));
    chk({tag, ".waddr"}, 64'(bus.out_waddr), 64'(waddr));
    chk({tag, ".wdata"}, bus.out_wdata, wdata);
    chk({tag, ".trap"},  64'(bus.out_trap), 64'(trap));
    chk({tag, ".cause"}, bus.out_cause, cause);
    chk({tag, ".seq"},   64'(bus.out_seq), 64'(seq));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid   = '0;
    bus.in_pc      = '0;
    bus.in_insn    = '0;
    bus.in_wen     = '0;
    bus.in_waddr   = '0;
    bus.in_wdata   = '0;
    bus.trap_valid = 1'b0;
    bus.trap_cause = '0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [63:0] pc, input logic [31:0] insn,
                          input logic wen, input logic [4:0] waddr, input logic [63:0] wdata);
    bus.in_valid[i]         = v;
    bus.in_pc[64*i +: 64]   = pc;
    bus.in_insn[32*i +: 32] = insn;
    bus.in_wen[i]           = wen;
    bus.in_waddr[5*i +: 5]  = waddr;
    bus.in_wdata[64*i +: 64] = wdata;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    clear_in();
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Idle after reset release
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst.in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst.out_seq",   64'(bus.out_seq),   64'd0);
    end
    chk("rst.overflow", 64'(bus.overflow), 64'd0);
    chk("rst.out_pc",   bus.out_pc, 64'd0);

    // Two lanes plus trap in one cycle; lane 0 wen=0 must zero its waddr/wdata
    set_lane(0, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 5'd3, 64'h77);
    set_lane(1, 1'b1, 64'h8000_0004, 32'h0de0_0293, 1'b1, 5'd5, 64'hdead);
    bus.trap_valid = 1'b1;
    bus.trap_cause = 64'd2;
    bus.out_ready  = 1'b1;
    step();
    clear_in();
    chk_rec("grp.r0", 64'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 64'h0,    1'b0, 64'd0, 32'd0);
    step();
    chk_rec("grp.r1", 64'h8000_0004, 32'h0de0_0293, 1'b1, 5'd5, 64'hdead, 1'b0, 64'd0, 32'd1);
    step();
    chk_rec("grp.r2", 64'h0,         32'h0,         1'b0, 5'd0, 64'h0,    1'b1, 64'd2, 32'd2);
    step();
    chk("grp.empty_valid", 64'(bus.out_valid), 64'd0);
    chk("grp.empty_pc",    bus.out_pc, 64'd0);
    chk("grp.empty_trap",  64'(bus.out_trap), 64'd0);
    chk("grp.empty_seq",   64'(bus.out_seq), 64'd3);

    // Lane 1 only, wen=0: compacted to one record with zeroed write fields
    set_lane(0, 1'b0, 64'h9999, 32'h1, 1'b1, 5'd9, 64'h99);
    set_lane(1, 1'b1, 64'h100,  32'h0000_0033, 1'b0, 5'd7, 64'h55);
    step();
    clear_in();
    chk_rec("gap.r0", 64'h100, 32'h0000_0033, 1'b0, 5'd0, 64'h0, 1'b0, 64'd0, 32'd3);
    step();
    chk("gap.empty_valid", 64'(bus.out_valid), 64'd0);
    chk("gap.seq",         64'(bus.out_seq), 64'd4);

    // Fill with checker stalled until in_ready drops at count 6
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 1'b1, 64'h1000 + 64'(8*k), 32'h0, 1'b0, 5'd0, 64'h0);
      set_lane(1, 1'b1, 64'h1004 + 64'(8*k), 32'h0, 1'b0, 5'd0, 64'h0);
      step();
      chk("fill.in_ready", 64'(bus.in_ready), (k < 2) ? 64'd1 : 64'd0);
    end
    chk("fill.head_pc",  bus.out_pc, 64'h1000);
    chk("fill.overflow", 64'(bus.overflow), 64'd0);
    set_lane(0, 1'b1, 64'h2000, 32'h0, 1'b0, 5'd0, 64'h0);
    set_lane(1, 1'b1, 64'h2004, 32'h0, 1'b0, 5'd0, 64'h0);
    step();
    clear_in();
    chk("ovf.overflow", 64'(bus.overflow), 64'd1);
    chk("ovf.in_ready", 64'(bus.in_ready), 64'd0);
    chk("ovf.head_pc",  bus.out_pc, 64'h1000);
    chk("ovf.head_seq", 64'(bus.out_seq), 64'd4);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("drain.valid",    64'(bus.out_valid), 64'd1);
      chk("drain.pc",       bus.out_pc, 64'h1000 + 64'(4*j));
      chk("drain.seq",      64'(bus.out_seq), 64'(4 + j));
      chk("drain.in_ready", 64'(bus.in_ready), (j > 0) ? 64'd1 : 64'd0);
      step();
    end
    chk("drain.empty",    64'(bus.out_valid), 64'd0);
    chk("drain.seq_end",  64'(bus.out_seq), 64'd10);
    chk("drain.overflow", 64'(bus.overflow), 64'd1);

    // Sequence counter wrap via preload
    force dut.seq_q = 32'hFFFF_FFFE;
    #1;
    release dut.seq_q;
    set_lane(0, 1'b1, 64'h3000, 32'h0, 1'b0, 5'd0, 64'h0);
    set_lane(1, 1'b1, 64'h3004, 32'h0, 1'b0, 5'd0, 64'h0);
    bus.trap_valid = 1'b1;
    bus.trap_cause = 64'h8000_0000_0000_0007;
    step();
    clear_in();
    chk_rec("wrap.r0", 64'h3000, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'd0, 32'hFFFF_FFFE);
    step();
    chk_rec("wrap.r1", 64'h3004, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'd0, 32'hFFFF_FFFF);
    step();
    chk_rec("wrap.r2", 64'h0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b1, 64'h8000_0000_0000_0007, 32'd0);
    step();
    chk("wrap.empty", 64'(bus.out_valid), 64'd0);
    chk("wrap.seq",   64'(bus.out_seq), 64'd1);

    // Asynchronous reset with four records queued
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_lane(0, 1'b1, 64'h4000 + 64'(8*k), 32'h0, 1'b0, 5'd0, 64'h0);
      set_lane(1, 1'b1, 64'h4004 + 64'(8*k), 32'h0, 1'b0, 5'd0, 64'h0);
      step();
    end
    clear_in();
    chk("mrst.pre_valid", 64'(bus.out_valid), 64'd1);
    chk("mrst.pre_pc",    bus.out_pc, 64'h4000);
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.valid",    64'(bus.out_valid), 64'd0);
    chk("mrst.overflow", 64'(bus.overflow), 64'd0);
    chk("mrst.seq",      64'(bus.out_seq), 64'd0);
    chk("mrst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("mrst.pc",       bus.out_pc, 64'd0);
    #2 rst_n = 1'b1;
    set_lane(0, 1'b1, 64'hABC, 32'h0000_0073, 1'b1, 5'd1, 64'h1234);
    step();
    clear_in();
    chk_rec("post.r0", 64'hABC, 32'h0000_0073, 1'b1, 5'd1, 64'h1234, 1'b0, 64'd0, 32'd0);
    step();
    chk("post.empty", 64'(bus.out_valid), 64'd0);
    chk("post.seq",   64'(bus.out_seq), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
